tap_loader: RTL and testbench
=============================

TAP_LOADER -- requirements
Module: tap_loader

Interface
REQ-001 Parameter TAP_INDEX, default 8'd1: ioctl_index value identifying a TAP download; other indices are ignored.
REQ-002 clk_sys  input  1  system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ioctl_download  input  1  high while the HPS streams a file.
REQ-005 ioctl_index  input  8  file-type index of the current download.
REQ-006 ioctl_wr  input  1  one-cycle strobe; ioctl_dout is valid.
REQ-007 ioctl_addr  input  25  byte offset in the file; informational only, not used for parsing.
REQ-008 ioctl_dout  input  8  file byte.
REQ-009 tape_addr  output  16  RAM write address (port B of system RAM).
REQ-010 tape_dout  output  8  RAM write data.
REQ-011 tape_wr  output  1  one-cycle RAM write strobe.
REQ-012 loadpoint  output  16  start address from the TAP header.
REQ-013 endpoint  output  16  end address from the TAP header.
REQ-014 tape_autorun  output  1  header autorun byte was non-zero.
REQ-015 tape_complete  output  1  level: last data byte of a file written.
REQ-016 tape_error  output  1  level: malformed or truncated file.

Function
REQ-017 Accepted byte = ioctl_wr & ioctl_download & (ioctl_index == TAP_INDEX); all other cycles are ignored.
REQ-018 Rising edge of ioctl_download with a matching index: state <= SYNC; sync count, tape_complete, tape_error, tape_autorun <= 0.
REQ-019 States: IDLE, SYNC, HEADER, NAME, DATA, DONE, ERROR.
REQ-020 SYNC: 0x16 increments a saturating 2-bit sync count; 0x24 with count==3 (at least three 0x16) -> HEADER, header index 0; any other byte, or 0x24 with count<3, clears the count.
REQ-021 HEADER: exactly 9 bytes. Byte 3 -> tape_autorun = |byte. Bytes 4/5 -> endpoint hi/lo. Bytes 6/7 -> loadpoint hi/lo. Bytes 0, 1, 2 and 8 are discarded. After byte 8 -> NAME.
REQ-022 NAME: bytes are discarded until 0x00, then -> DATA with tape_addr <= loadpoint. If 17 non-zero name bytes arrive -> ERROR.
REQ-023 On entry to DATA, endpoint < loadpoint -> ERROR; no byte is written.
REQ-024 DATA: each accepted byte drives tape_dout <= byte and tape_wr = 1 on the next cycle (latency 1). tape_addr holds the written address during the strobe, then increments.
REQ-025 Write of the byte at address == endpoint: tape_complete <= 1 in the same cycle as that tape_wr; state -> DONE. tape_addr is not incremented past endpoint; no wrap at 0xFFFF.
REQ-026 DONE: further bytes are ignored; tape_complete is held until the next matching download rising edge or reset.
REQ-027 Falling edge of ioctl_download while in SYNC, HEADER, NAME or DATA: tape_error <= 1, state -> ERROR. A falling edge in DONE is harmless.
REQ-028 ERROR: no writes; tape_error is held until the next matching download rising edge or reset.
REQ-029 An accepted byte coinciding with the download rising edge is processed as the first byte in SYNC.
REQ-030 tape_wr never asserts outside DATA, and never on two consecutive cycles unless ioctl_wr does.

Reset
REQ-031 reset: state IDLE; tape_addr, tape_dout, loadpoint, endpoint <= 0; tape_wr, tape_complete, tape_error, tape_autorun <= 0.
REQ-032 reset mid-DATA: the pending tape_wr is cancelled in the same cycle; no partial completion is flagged.

Configuration
REQ-033 Macro TAP_MULTIFILE_EN defined: DONE -> SYNC on the next accepted byte. A later file overwrites loadpoint, endpoint and tape_autorun. tape_complete pulses per file and is not held.
REQ-034 TAP_MULTIFILE_EN undefined: behaviour exactly per REQ-026; trailing data is ignored.

Verification
REQ-035 Stream 16 16 16 24, 00 00 80 01, C0 03 C0 00, 00, "AB" 00, then 4 data bytes -> writes at C000..C003; loadpoint=C000, endpoint=C003; tape_autorun=1; tape_complete=1 with the C003 write.
REQ-036 Stream 16 16 24 ... -> remains in SYNC; no writes. Adding one more 16 before 24 -> normal load.
REQ-037 Header end=1000, start=2000 -> tape_error=1; zero tape_wr strobes.
REQ-038 Download drops after 2 of 4 data bytes -> tape_error=1, tape_complete=0; exactly 2 writes occur.
REQ-039 reset asserted between two data bytes -> all outputs return to 0 next cycle; the next download reloads cleanly.
REQ-040 With TAP_MULTIFILE_EN, two concatenated files (C000..C001, then 0500..0500) -> 3 writes and 2 tape_complete pulses; final loadpoint=0500.

Source files
------------

// File: rtl/tap_loader.sv
// tap_loader: parses a TAP file streamed over ioctl and writes its payload into system RAM.
// Ports: clk_sys/reset (sync, active-high); ioctl_download/index/wr/addr/dout from the HPS;
//        tape_addr/tape_dout/tape_wr drive RAM port B; loadpoint/endpoint/tape_autorun come
//        from the header; tape_complete/tape_error are status levels.
// Optional macro TAP_MULTIFILE_EN: after a completed file, the next byte restarts sync so
//        concatenated files load back to back and tape_complete becomes a per-file pulse.
module tap_loader #(
   parameter logic [7:0] TAP_INDEX = 8'd1
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic [15:0] tape_addr,
   output logic [7:0]  tape_dout,
   output logic        tape_wr,
   output logic [15:0] loadpoint,
   output logic [15:0] endpoint,
   output logic        tape_autorun,
   output logic        tape_complete,
   output logic        tape_error
);
   localparam logic [2:0] IDLE = 3'd0, SYNC = 3'd1, HEADER = 3'd2, NAME = 3'd3,
                          DATA = 3'd4, DONE = 3'd5, ERROR = 3'd6;
   logic [2:0]  state, cur;
   logic [1:0]  sync_cnt, sync_cur;
   logic [3:0]  hdr_idx;
   logic [4:0]  name_cnt;
   logic [15:0] next_addr;
   logic        dl_prev, match, acc, rise, fall;
   logic        unused_addr;
   assign unused_addr = ^ioctl_addr;
   assign match = ioctl_index == TAP_INDEX;
   assign acc   = ioctl_wr & ioctl_download & match;
   assign rise  = ioctl_download & ~dl_prev & match;
   assign fall  = ~ioctl_download & dl_prev;
   // A byte arriving with the download rising edge (or, in multifile mode, right after a
   // completed file) is parsed as if the machine were already in SYNC with a cleared count.
   always_comb begin
`ifdef TAP_MULTIFILE_EN
      cur      = (rise || (state == DONE && acc)) ? SYNC : state;
      sync_cur = (rise || state == DONE) ? 2'd0 : sync_cnt;
`else
      cur      = rise ? SYNC : state;
      sync_cur = rise ? 2'd0 : sync_cnt;
`endif
      // the address advances only once the strobe holding it has been issued
      next_addr = (tape_wr && state == DATA) ? tape_addr + 16'd1 : tape_addr;
   end
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state         <= IDLE;
         sync_cnt      <= 2'd0;
         hdr_idx       <= 4'd0;
         name_cnt      <= 5'd0;
         dl_prev       <= 1'b0;
         tape_addr     <= 16'd0;
         tape_dout     <= 8'd0;
         tape_wr       <= 1'b0;
         loadpoint     <= 16'd0;
         endpoint      <= 16'd0;
         tape_autorun  <= 1'b0;
         tape_complete <= 1'b0;
         tape_error    <= 1'b0;
      end else begin
         dl_prev   <= ioctl_download;
         tape_wr   <= 1'b0;
         tape_addr <= next_addr;
         state     <= cur;
         sync_cnt  <= sync_cur;
`ifdef TAP_MULTIFILE_EN
         tape_complete <= 1'b0;
`endif
         if (rise) begin
            tape_complete <= 1'b0;
            tape_error    <= 1'b0;
            tape_autorun  <= 1'b0;
         end
         if (fall && state inside {SYNC, HEADER, NAME, DATA}) begin
            state      <= ERROR;
            tape_error <= 1'b1;
         end else if (acc) begin
            case (cur)
               SYNC: begin
                  sync_cnt <= (ioctl_dout == 8'h16) ? ((sync_cur == 2'd3) ? 2'd3 : sync_cur + 2'd1) : 2'd0;
                  state    <= (ioctl_dout == 8'h24 && sync_cur == 2'd3) ? HEADER : SYNC;
                  hdr_idx  <= 4'd0;
               end
               HEADER: begin
                  hdr_idx <= hdr_idx + 4'd1;
                  if (hdr_idx == 4'd3) tape_autorun <= |ioctl_dout;
                  if (hdr_idx == 4'd4) endpoint[15:8] <= ioctl_dout;
                  if (hdr_idx == 4'd5) endpoint[7:0] <= ioctl_dout;
                  if (hdr_idx == 4'd6) loadpoint[15:8] <= ioctl_dout;
                  if (hdr_idx == 4'd7) loadpoint[7:0] <= ioctl_dout;
                  if (hdr_idx == 4'd8) begin
                     state    <= NAME;
                     name_cnt <= 5'd0;
                  end
               end
               NAME: begin
                  if (ioctl_dout == 8'h00 && endpoint < loadpoint) begin
                     state      <= ERROR;
                     tape_error <= 1'b1;
                  end else if (ioctl_dout == 8'h00) begin
                     state     <= DATA;
                     tape_addr <= loadpoint;
                  end else if (name_cnt == 5'd16) begin
                     state      <= ERROR;
                     tape_error <= 1'b1;
                  end else begin
                     name_cnt <= name_cnt + 5'd1;
                  end
               end
               DATA: begin
                  tape_dout <= ioctl_dout;
                  tape_wr   <= 1'b1;
                  if (next_addr == endpoint) begin
                     tape_complete <= 1'b1;
                     state         <= DONE;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_tap_loader.sv
// tb_tap_loader: directed self-checking bench for tap_loader.
module tb_tap_loader;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = 8'd1;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = 25'd0;
   logic [7:0]  ioctl_dout = 8'd0;
   logic [15:0] tape_addr, loadpoint, endpoint;
   logic [7:0]  tape_dout;
   logic        tape_wr, tape_autorun, tape_complete, tape_error;
   int checks = 0;
   int failures = 0;
   int wr_cnt = 0;
   int cpl_wr = 0;
   int cpl_rise = 0;
   logic cpl_prev = 1'b0;
   logic [15:0] log_addr [64];
   logic [7:0]  log_data [64];
   int b_wr, b_cw, b_cr;
`ifdef TAP_MULTIFILE_EN
   localparam logic HOLD = 1'b0;
`else
   localparam logic HOLD = 1'b1;
`endif

   tap_loader #(.TAP_INDEX(8'd1)) dut (
      .clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .tape_addr(tape_addr), .tape_dout(tape_dout), .tape_wr(tape_wr),
      .loadpoint(loadpoint), .endpoint(endpoint), .tape_autorun(tape_autorun),
      .tape_complete(tape_complete), .tape_error(tape_error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tape_wr) begin
         log_addr[wr_cnt % 64] = tape_addr;
         log_data[wr_cnt % 64] = tape_dout;
         if (tape_complete) cpl_wr = cpl_wr + 1;
         wr_cnt = wr_cnt + 1;
      end
      if (tape_complete && !cpl_prev) cpl_rise = cpl_rise + 1;
      cpl_prev = tape_complete;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      ioctl_wr = 1'b1;
      ioctl_dout = b;
      ioctl_addr = ioctl_addr + 25'd1;
      @(negedge clk);
      ioctl_wr = 1'b0;
   endtask

   task automatic mark();
      b_wr = wr_cnt;
      b_cw = cpl_wr;
      b_cr = cpl_rise;
   endtask

   task automatic dl_on(input logic [7:0] idx);
      @(negedge clk);
      ioctl_index = idx;
      ioctl_download = 1'b1;
      ioctl_addr = 25'd0;
      repeat (2) @(negedge clk);
   endtask

   task automatic dl_off();
      @(negedge clk);
      ioctl_download = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_file(input int nsync, input int nname, input logic [15:0] ld,
                            input logic [15:0] en, input logic [7:0] ar, input int n,
                            input logic [7:0] d0);
      for (int i = 0; i < nsync; i++) send(8'h16);
      send(8'h24);
      send(8'h00); send(8'h00); send(8'h80); send(ar);
      send(en[15:8]); send(en[7:0]); send(ld[15:8]); send(ld[7:0]); send(8'h00);
      for (int i = 0; i < nname; i++) send(8'h41 + 8'(i));
      send(8'h00);
      for (int i = 0; i < n; i++) send(d0 + 8'(i));
      repeat (2) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_addr_dout", {tape_addr, tape_dout}, 0);
      chk("reset_points", {loadpoint, endpoint}, 0);
      chk("reset_flags", {tape_wr, tape_complete, tape_error, tape_autorun}, 0);
      reset = 1'b0;

      // standard file: C000..C003, autorun, name "AB"
      mark();
      dl_on(8'd1);
      send_file(3, 2, 16'hC000, 16'hC003, 8'h01, 0, 8'h00);
      chk("hdr_loadpoint", loadpoint, 16'hC000);
      chk("hdr_endpoint", endpoint, 16'hC003);
      chk("hdr_autorun", tape_autorun, 1);
      chk("pre_data_writes", wr_cnt - b_wr, 0);
      chk("pre_data_complete", tape_complete, 0);
      for (int i = 0; i < 4; i++) send(8'hAA + 8'(i));
      repeat (2) @(negedge clk);
      chk("std_writes", wr_cnt - b_wr, 4);
      chk("std_w0", {log_addr[b_wr % 64], log_data[b_wr % 64]}, {16'hC000, 8'hAA});
      chk("std_w1", {log_addr[(b_wr + 1) % 64], log_data[(b_wr + 1) % 64]}, {16'hC001, 8'hAB});
      chk("std_w3", {log_addr[(b_wr + 3) % 64], log_data[(b_wr + 3) % 64]}, {16'hC003, 8'hAD});
      chk("std_cpl_with_last_wr", cpl_wr - b_cw, 1);
      chk("std_addr_no_advance", tape_addr, 16'hC003);
      dl_off();
      chk("std_complete_level", tape_complete, HOLD);
      chk("std_error", tape_error, 0);

      // only two sync bytes: stays in SYNC; then a proper sync loads normally
      mark();
      dl_on(8'd1);
      chk("rise_clears_complete", {tape_complete, tape_autorun}, 0);
      send_file(2, 1, 16'h2000, 16'h2001, 8'h00, 2, 8'h90);
      chk("short_sync_writes", wr_cnt - b_wr, 0);
      chk("short_sync_loadpoint", loadpoint, 16'hC000);
      send_file(3, 1, 16'h2000, 16'h2001, 8'h00, 2, 8'h90);
      chk("resync_writes", wr_cnt - b_wr, 2);
      chk("resync_w1", {log_addr[(b_wr + 1) % 64], log_data[(b_wr + 1) % 64]}, {16'h2001, 8'h91});
      chk("resync_flags", {tape_complete, tape_error, tape_autorun}, {HOLD, 2'b00});
      dl_off();

      // end below start
      mark();
      dl_on(8'd1);
      send_file(3, 0, 16'h2000, 16'h1000, 8'h00, 2, 8'h11);
      dl_off();
      chk("badrange_error", tape_error, 1);
      chk("badrange_writes", wr_cnt - b_wr, 0);
      chk("badrange_complete", tape_complete, 0);

      // truncated download after 2 of 4 data bytes
      mark();
      dl_on(8'd1);
      chk("rise_clears_error", tape_error, 0);
      send_file(3, 1, 16'h3000, 16'h3003, 8'h00, 2, 8'h50);
      dl_off();
      chk("trunc_error_complete", {tape_error, tape_complete}, 2'b10);
      chk("trunc_writes", wr_cnt - b_wr, 2);
      chk("trunc_last", {log_addr[(b_wr + 1) % 64], log_data[(b_wr + 1) % 64]}, {16'h3001, 8'h51});

      // reset between data bytes, with a byte arriving during reset
      mark();
      dl_on(8'd1);
      send_file(3, 1, 16'h4000, 16'h4003, 8'h01, 1, 8'h60);
      chk("prereset_writes", wr_cnt - b_wr, 1);
      @(negedge clk);
      ioctl_wr = 1'b1;
      ioctl_dout = 8'h61;
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_wr", tape_wr, 0);
      chk("rst_mid_outs", {tape_addr, tape_dout, loadpoint, endpoint}, 0);
      chk("rst_mid_flags", {tape_complete, tape_error, tape_autorun}, 0);
      reset = 1'b0;
      ioctl_wr = 1'b0;
      ioctl_download = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_no_extra_write", wr_cnt - b_wr, 1);
      mark();
      dl_on(8'd1);
      send_file(3, 2, 16'h5000, 16'h5001, 8'h00, 2, 8'h70);
      dl_off();
      chk("reload_writes", wr_cnt - b_wr, 2);
      chk("reload_w0", {log_addr[b_wr % 64], log_data[b_wr % 64]}, {16'h5000, 8'h70});
      chk("reload_flags", {tape_complete, tape_error}, {HOLD, 1'b0});

      // accepted byte on the same cycle as the download rising edge counts as a sync byte
      mark();
      @(negedge clk);
      ioctl_index = 8'd1;
      ioctl_download = 1'b1;
      ioctl_wr = 1'b1;
      ioctl_dout = 8'h16;
      @(negedge clk);
      ioctl_wr = 1'b0;
      send_file(2, 0, 16'h6000, 16'h6000, 8'h00, 1, 8'h80);
      chk("coincident_writes", wr_cnt - b_wr, 1);
      chk("coincident_w0", {log_addr[b_wr % 64], log_data[b_wr % 64]}, {16'h6000, 8'h80});
      chk("coincident_cpl", cpl_wr - b_cw, 1);
      dl_off();

      // top of address space: no wrap past FFFF
      mark();
      dl_on(8'd1);
      send_file(3, 0, 16'hFFFE, 16'hFFFF, 8'h00, 2, 8'hA0);
      chk("top_writes", wr_cnt - b_wr, 2);
      chk("top_w1", {log_addr[(b_wr + 1) % 64], log_data[(b_wr + 1) % 64]}, {16'hFFFF, 8'hA1});
      chk("top_addr_hold", tape_addr, 16'hFFFF);
      chk("top_cpl", cpl_wr - b_cw, 1);
      dl_off();

      // 17-character name is malformed
      mark();
      dl_on(8'd1);
      send_file(3, 17, 16'h7000, 16'h7001, 8'h00, 2, 8'hB0);
      chk("longname_error", tape_error, 1);
      chk("longname_writes", wr_cnt - b_wr, 0);
      dl_off();

      // foreign index is ignored entirely
      mark();
      dl_on(8'd2);
      send_file(3, 1, 16'h7100, 16'h7101, 8'h01, 2, 8'hB8);
      chk("foreign_writes", wr_cnt - b_wr, 0);
      chk("foreign_loadpoint", loadpoint, 16'h7000);
      chk("foreign_error_held", tape_error, 1);
      dl_off();

      // two concatenated files in one download
      mark();
      dl_on(8'd1);
      send_file(3, 1, 16'hC000, 16'hC001, 8'h01, 2, 8'hC0);
      send_file(3, 1, 16'h0500, 16'h0500, 8'h00, 1, 8'hD0);
      dl_off();
`ifdef TAP_MULTIFILE_EN
      chk("concat_writes", wr_cnt - b_wr, 3);
      chk("concat_pulses", cpl_rise - b_cr, 2);
      chk("concat_loadpoint", loadpoint, 16'h0500);
      chk("concat_w2", {log_addr[(b_wr + 2) % 64], log_data[(b_wr + 2) % 64]}, {16'h0500, 8'hD0});
      chk("concat_flags", {tape_complete, tape_error, tape_autorun}, 0);
`else
      chk("concat_writes", wr_cnt - b_wr, 2);
      chk("concat_pulses", cpl_rise - b_cr, 1);
      chk("concat_loadpoint", loadpoint, 16'hC000);
      chk("concat_flags", {tape_complete, tape_error, tape_autorun}, 3'b101);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
